// File: rtl/cache_memory_if.sv
// CPU-side and memory-side signals of the data cache, grouped as one bundle.
// The slave modport is the cache itself; the master modport is the CPU/memory environment.
interface cache_memory_if;
  logic         read;
  logic         write;
  logic [31:0]  address;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  logic         inst_hit;

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait, inst_hit,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait, inst_hit,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/cache_memory.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word blocks.
// Misses evict a dirty line first, then fetch the block and complete as a hit.
module cache_memory #(
  parameter int INDEX_BITS = 3
) (
  input logic           CLK,
  input logic           RESET,
  cache_memory_if.slave bus
);
  localparam int SETS  = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MEM_WRITE, MEM_READ, UPDATE} state_t;

  state_t state, state_next;

  logic [SETS-1:0]  valid;
  logic [SETS-1:0]  dirty;
  logic [TAG_W-1:0] tag_array  [SETS];
  logic [127:0]     data_array [SETS];

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic [1:0]            req_word;
  logic [TAG_W-1:0]      line_tag;
  logic [127:0]          line_data;
  logic                  line_valid;
  logic                  line_dirty;
  logic                  hit;
  logic                  request;
  logic                  commit_write;
  logic                  fill;
  logic                  unused_addr_bits;

  function automatic logic [31:0] get_word(input logic [127:0] block, input logic [1:0] sel);
    return block[{sel, 5'b0} +: 32];
  endfunction

  function automatic logic [127:0] merge_word(input logic [127:0] block, input logic [1:0] sel,
                                              input logic [31:0] word);
    logic [127:0] r;
    r = block;
    r[{sel, 5'b0} +: 32] = word;
    return r;
  endfunction

  assign req_tag          = bus.address[31:4+INDEX_BITS];
  assign req_index        = bus.address[3+INDEX_BITS:4];
  assign req_word         = bus.address[3:2];
  assign unused_addr_bits = &{1'b0, bus.address[1:0]};

  assign line_tag   = tag_array[req_index];
  assign line_data  = data_array[req_index];
  assign line_valid = valid[req_index];
  assign line_dirty = dirty[req_index];

  assign hit     = line_valid && (line_tag == req_tag);
  assign request = bus.read | bus.write;
  // A simultaneous read+write is a write; it commits only once the line is present.
  assign commit_write = RESET && (state == IDLE) && bus.write && hit && bus.inst_hit;
  assign fill         = (state == UPDATE);

  assign bus.busywait = RESET && request && !((state == IDLE) && hit);
  assign bus.readdata = (RESET && hit) ? get_word(line_data, req_word) : 32'd0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_next;
      if (fill) begin
        valid[req_index] <= 1'b1;
        dirty[req_index] <= 1'b0;
      end else if (commit_write) begin
        dirty[req_index] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      data_array[req_index] <= bus.mem_readdata;
      tag_array[req_index]  <= req_tag;
    end else if (commit_write) begin
      data_array[req_index] <= merge_word(line_data, req_word, bus.writedata);
    end
  end

  always_comb begin
    state_next        = state;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;
    unique case (state)
      IDLE: begin
        if (request && !hit && bus.inst_hit)
          state_next = (line_valid && line_dirty) ? MEM_WRITE : MEM_READ;
      end
      MEM_WRITE: begin
        bus.mem_write     = 1'b1;
        bus.mem_address   = {line_tag, req_index};
        bus.mem_writedata = line_data;
        if (!bus.mem_busywait) state_next = MEM_READ;
      end
      MEM_READ: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = {req_tag, req_index};
        if (!bus.mem_busywait) state_next = UPDATE;
      end
      UPDATE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_memory.sv
// Directed bench for cache_memory: fills, hits, eviction, inst_hit gating, reset abort.
module tb_cache_memory;
  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  localparam logic [127:0] BLK1 = {32'h0001_0003, 32'h0001_0002, 32'h0001_0001, 32'h0001_0000};
  localparam logic [127:0] BLK9 = {32'h0009_0003, 32'h0009_0002, 32'h0009_0001, 32'h0009_0000};
  localparam logic [127:0] BLK2 = {32'h0002_0003, 32'h0002_0002, 32'h0002_0001, 32'h0002_0000};
  localparam logic [127:0] BLK3 = {32'h0003_0003, 32'h0003_0002, 32'h0003_0001, 32'h0003_0000};
  localparam logic [127:0] EVICT1 = {32'h0001_0003, 32'h0001_0002, 32'hDEAD_BEEF, 32'h0001_0000};
  localparam logic [127:0] EVICT3 = {32'h0003_0003, 32'h0003_0002, 32'hCAFE_F00D, 32'h0003_0000};

  cache_memory_if bif ();

  cache_memory #(.INDEX_BITS(3)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    bif.read = 1'b1;
    bif.write = 1'b0;
    bif.address = 32'h10;
    bif.writedata = 32'd0;
    bif.mem_readdata = '0;
    bif.mem_busywait = 1'b1;
    bif.inst_hit = 1'b1;
    #2;
    check("rst_busywait", bif.busywait, 1'b0);
    check("rst_mem_read", bif.mem_read, 1'b0);
    check("rst_mem_write", bif.mem_write, 1'b0);
    check("rst_mem_address", bif.mem_address, 28'd0);
    check("rst_mem_writedata", bif.mem_writedata, 128'd0);
    check("rst_readdata", bif.readdata, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("miss_busy", bif.busywait, 1'b1);
    check("miss_idle_no_read", bif.mem_read, 1'b0);

    // Cold read miss on 0x10: block 1 fetched, word 0 returned
    tick();
    check("fill_mem_read", bif.mem_read, 1'b1);
    check("fill_mem_write", bif.mem_write, 1'b0);
    check("fill_mem_address", bif.mem_address, 28'h000_0001);
    check("fill_busy", bif.busywait, 1'b1);
    bif.mem_readdata = BLK1;
    bif.mem_busywait = 1'b0;
    tick();
    bif.mem_busywait = 1'b1;
    #1;
    check("update_mem_read", bif.mem_read, 1'b0);
    check("update_mem_write", bif.mem_write, 1'b0);
    check("update_busy", bif.busywait, 1'b1);
    tick();
    check("fill_done_busy", bif.busywait, 1'b0);
    check("fill_readdata_w0", bif.readdata, 32'h0001_0000);
    bif.address = 32'h14;
    #1;
    check("hit_readdata_w1", bif.readdata, 32'h0001_0001);
    check("hit_busy", bif.busywait, 1'b0);

    // Write hit then read hit, no stall
    bif.read = 1'b0;
    bif.write = 1'b1;
    bif.writedata = 32'hDEAD_BEEF;
    #1;
    check("write_hit_busy", bif.busywait, 1'b0);
    tick();
    bif.write = 1'b0;
    bif.read = 1'b1;
    #1;
    check("readback_busy", bif.busywait, 1'b0);
    check("readback_data", bif.readdata, 32'hDEAD_BEEF);
    bif.address = 32'h10;
    #1;
    check("readback_w0_kept", bif.readdata, 32'h0001_0000);

    // Conflict miss on 0x94 evicts dirty block 1, then fetches block 9
    bif.address = 32'h94;
    #1;
    check("evict_miss_busy", bif.busywait, 1'b1);
    tick();
    check("evict_mem_write", bif.mem_write, 1'b1);
    check("evict_mem_read", bif.mem_read, 1'b0);
    check("evict_mem_address", bif.mem_address, 28'h000_0001);
    check("evict_word1", bif.mem_writedata[63:32], 32'hDEAD_BEEF);
    check("evict_block", bif.mem_writedata, EVICT1);
    tick();
    check("evict_hold", bif.mem_write, 1'b1);
    bif.mem_busywait = 1'b0;
    tick();
    bif.mem_busywait = 1'b1;
    #1;
    check("refill_mem_read", bif.mem_read, 1'b1);
    check("refill_mem_write", bif.mem_write, 1'b0);
    check("refill_mem_address", bif.mem_address, 28'h000_0009);
    bif.mem_readdata = BLK9;
    bif.mem_busywait = 1'b0;
    tick();
    bif.mem_busywait = 1'b1;
    tick();
    check("refill_busy", bif.busywait, 1'b0);
    check("refill_readdata", bif.readdata, 32'h0009_0001);

    // inst_hit low holds a pending miss in IDLE
    bif.inst_hit = 1'b0;
    bif.address = 32'h20;
    #1;
    check("ih_busy", bif.busywait, 1'b1);
    tick();
    check("ih_hold_mem_read", bif.mem_read, 1'b0);
    check("ih_hold_busy", bif.busywait, 1'b1);
    bif.inst_hit = 1'b1;
    tick();
    check("ih_go_mem_read", bif.mem_read, 1'b1);
    check("ih_go_mem_address", bif.mem_address, 28'h000_0002);

    // Reset in MEM_READ aborts at once and invalidates every line
    rst_n = 1'b0;
    #1;
    check("abort_mem_read", bif.mem_read, 1'b0);
    check("abort_busy", bif.busywait, 1'b0);
    check("abort_mem_address", bif.mem_address, 28'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_miss", bif.busywait, 1'b1);
    bif.address = 32'h94;
    #1;
    check("post_rst_invalid", bif.busywait, 1'b1);
    bif.address = 32'h20;
    tick();
    check("post_rst_mem_read", bif.mem_read, 1'b1);
    check("post_rst_mem_write", bif.mem_write, 1'b0);
    check("post_rst_address", bif.mem_address, 28'h000_0002);
    bif.mem_readdata = BLK2;
    bif.mem_busywait = 1'b0;
    tick();
    bif.mem_busywait = 1'b1;
    tick();
    check("post_rst_readdata", bif.readdata, 32'h0002_0000);

    // Read and write together on a miss: fill, then write, line becomes dirty
    bif.address = 32'h34;
    bif.write = 1'b1;
    bif.writedata = 32'hCAFE_F00D;
    #1;
    check("rw_miss_busy", bif.busywait, 1'b1);
    tick();
    check("rw_mem_read", bif.mem_read, 1'b1);
    check("rw_mem_write", bif.mem_write, 1'b0);
    check("rw_mem_address", bif.mem_address, 28'h000_0003);
    bif.mem_readdata = BLK3;
    bif.mem_busywait = 1'b0;
    tick();
    bif.mem_busywait = 1'b1;
    tick();
    check("rw_hit_busy", bif.busywait, 1'b0);
    tick();
    bif.write = 1'b0;
    #1;
    check("rw_readback", bif.readdata, 32'hCAFE_F00D);
    bif.address = 32'h30;
    #1;
    check("rw_w0_kept", bif.readdata, 32'h0003_0000);
    bif.address = 32'hB4;
    tick();
    check("rw_dirty_evict", bif.mem_write, 1'b1);
    check("rw_evict_address", bif.mem_address, 28'h000_0003);
    check("rw_evict_block", bif.mem_writedata, EVICT3);

    bif.read = 1'b0;
    rst_n = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
